// File: rtl/reduce_gate_pipe.sv
// reduce_gate_pipe: masked AND/OR/XOR/NAND/NOR/XNOR reduction, 2-stage valid/ready pipe; REDUCE_GATE_CNT_EN adds xfer_cnt
module reduce_gate_pipe #(
    parameter int PORT_NUM = 8,
    parameter int WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PORT_NUM*WIDTH-1:0] in_data,
    input  logic [PORT_NUM-1:0]       in_mask,
    input  logic [2:0]                in_op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_q,
    output logic                      out_err,
    output logic                      out_nomask
`ifdef REDUCE_GATE_CNT_EN
    ,
    output logic [15:0]               xfer_cnt
`endif
);
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_MAX  = 3'd5;
    logic                      s1_valid_q, s1_valid_d;
    logic [PORT_NUM*WIDTH-1:0] s1_data_q, s1_data_d;
    logic [2:0]                s1_op_q, s1_op_d;
    logic                      s1_nomask_q, s1_nomask_d;
    logic                      s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]          s2_res_q, s2_res_d;
    logic                      s2_err_q, s2_err_d;
    logic                      s2_nomask_q, s2_nomask_d;
    logic                      s1_adv, s2_adv, in_and, s1_and, s1_or;
    logic [WIDTH-1:0]          in_ident, acc, opnd;
    always_comb begin
        s2_adv      = !s2_valid_q || out_ready;
        s1_adv      = !s1_valid_q || s2_adv;
        in_and      = (in_op == OP_AND) || (in_op == OP_NAND);
        in_ident    = in_and ? '1 : '0;
        s1_valid_d  = s1_adv ? in_valid : s1_valid_q;
        s1_op_d     = s1_adv ? in_op : s1_op_q;
        s1_nomask_d = s1_adv ? (in_mask == '0) : s1_nomask_q;
        s1_data_d   = s1_data_q;
        for (int i = 0; i < PORT_NUM; i++)
            if (s1_adv)
                s1_data_d[i*WIDTH +: WIDTH] = in_mask[i] ? in_data[i*WIDTH +: WIDTH] : in_ident;
    end
    // Masked ports already hold the identity, so an empty mask reduces to it naturally.
    always_comb begin
        s1_and = (s1_op_q == OP_AND) || (s1_op_q == OP_NAND);
        s1_or  = (s1_op_q == OP_OR) || (s1_op_q == OP_NOR);
        acc    = s1_and ? '1 : '0;
        opnd   = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            opnd = s1_data_q[i*WIDTH +: WIDTH];
            acc  = s1_and ? (acc & opnd) : s1_or ? (acc | opnd) : (acc ^ opnd);
        end
        s2_valid_d  = s2_adv ? s1_valid_q : s2_valid_q;
        s2_err_d    = s2_adv ? (s1_op_q > OP_MAX) : s2_err_q;
        s2_nomask_d = s2_adv ? s1_nomask_q : s2_nomask_q;
        s2_res_d    = !s2_adv ? s2_res_q :
                      (s1_op_q > OP_MAX) ? '0 :
                      (s1_op_q >= OP_NAND) ? ~acc : acc;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_op_q     <= '0;
            s1_nomask_q <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_res_q    <= '0;
            s2_err_q    <= 1'b0;
            s2_nomask_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_op_q     <= s1_op_d;
            s1_nomask_q <= s1_nomask_d;
            s2_valid_q  <= s2_valid_d;
            s2_res_q    <= s2_res_d;
            s2_err_q    <= s2_err_d;
            s2_nomask_q <= s2_nomask_d;
        end
    end
    assign in_ready   = s1_adv;
    assign out_valid  = s2_valid_q;
    assign out_q      = s2_res_q;
    assign out_err    = s2_err_q;
    assign out_nomask = s2_nomask_q;
`ifdef REDUCE_GATE_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    always_comb cnt_d = (s2_valid_q && out_ready) ? cnt_q + 16'd1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign xfer_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_reduce_gate_pipe.sv
// tb_reduce_gate_pipe: directed vectors with a queue scoreboard and an independent output monitor
module tb_reduce_gate_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [7:0]  in_mask;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_q;
    logic        out_err;
    logic        out_nomask;
`ifdef REDUCE_GATE_CNT_EN
    logic [15:0] xfer_cnt;
`endif
    int          checks = 0;
    int          fails  = 0;
    logic [9:0]  sb[$];
    logic        held = 1'b0;
    logic [9:0]  held_v;

    reduce_gate_pipe #(.PORT_NUM(8), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mask(in_mask), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
        .out_err(out_err), .out_nomask(out_nomask)
`ifdef REDUCE_GATE_CNT_EN
        , .xfer_cnt(xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a transaction, wait (bounded) for in_ready, record expected {q,err,nomask}.
    task automatic send(input logic [63:0] d, input logic [7:0] m, input logic [2:0] op,
                        input logic [9:0] e);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mask  = m;
        in_op    = op;
        #1;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        end else sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: samples between the input-driving negedge and the next rising edge.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid) begin
            if (held) check("stall_hold", {22'd0, out_q, out_err, out_nomask}, {22'd0, held_v});
            if (out_ready) begin
                held = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_output: got q=0x%0h with empty scoreboard, expected none", out_q);
                end else check("result", {22'd0, out_q, out_err, out_nomask}, {22'd0, sb.pop_front()});
            end else begin
                held   = 1'b1;
                held_v = {out_q, out_err, out_nomask};
            end
        end else held = 1'b0;
    end

    initial begin
        int w;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mask   = '0;
        in_op     = '0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_q", {24'd0, out_q}, 0);
        check("rst_out_err", {31'd0, out_err}, 0);
        check("rst_out_nomask", {31'd0, out_nomask}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(64'h3CFF_FFFF_FFFF_F0FF, 8'hFF, 3'd0, {8'h30, 1'b0, 1'b0});
        in_valid = 1'b0;
        #1;
        check("latency_not_yet", {31'd0, out_valid}, 0);
        @(negedge clk);
        #1;
        check("latency_valid", {31'd0, out_valid}, 1);
        check("latency_q", {24'd0, out_q}, 32'h30);
        @(negedge clk);
        // Back-to-back stream of assorted ops and masks.
        send(64'hFFFF_FFFF_FF0F_FFA5, 8'h05, 3'd5, {8'h55, 1'b0, 1'b0});
        send(64'hFFFF_FFFF_FF0F_FFA5, 8'h05, 3'd3, {8'hFA, 1'b0, 1'b0});
        send(64'h800F_0F0F_0F0F_0F01, 8'h81, 3'd1, {8'h81, 1'b0, 1'b0});
        send(64'h3CFF_FFFF_FFFF_F0FF, 8'hFF, 3'd2, {8'hCC, 1'b0, 1'b0});
        send(64'hFFFF_FFFF_FFFF_0110, 8'h03, 3'd4, {8'hEE, 1'b0, 1'b0});
        send(64'h1234_5678_9ABC_DEF0, 8'h00, 3'd4, {8'hFF, 1'b0, 1'b1});
        send(64'h1234_5678_9ABC_DEF0, 8'h00, 3'd0, {8'hFF, 1'b0, 1'b1});
        send(64'h1234_5678_9ABC_DEF0, 8'h00, 3'd3, {8'h00, 1'b0, 1'b1});
        send(64'h1234_5678_9ABC_DEF0, 8'h00, 3'd5, {8'hFF, 1'b0, 1'b1});
        send(64'h1234_5678_9ABC_DEF0, 8'hFF, 3'd7, {8'h00, 1'b1, 1'b0});
        send(64'h1234_5678_9ABC_DEF0, 8'hFF, 3'd6, {8'h00, 1'b1, 1'b0});
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        // Backpressure: two fill the pipe, a third is held off while out_ready is low.
        out_ready = 1'b0;
        send({8{8'h11}}, 8'h01, 3'd1, {8'h11, 1'b0, 1'b0});
        send({8{8'h22}}, 8'h01, 3'd1, {8'h22, 1'b0, 1'b0});
        #1;
        check("bp_in_ready_low", {31'd0, in_ready}, 0);
        check("bp_out_valid", {31'd0, out_valid}, 1);
        check("bp_out_q", {24'd0, out_q}, 32'h11);
        in_data = {8{8'h33}};
        @(negedge clk);
        out_ready = 1'b1;
        send({8{8'h33}}, 8'h01, 3'd1, {8'h33, 1'b0, 1'b0});
        send({8{8'h44}}, 8'h01, 3'd1, {8'h44, 1'b0, 1'b0});
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("bp_drained", sb.size(), 0);
        // Reset with both stages occupied.
        out_ready = 1'b0;
        send({8{8'h55}}, 8'hFF, 3'd0, {8'h55, 1'b0, 1'b0});
        send({8{8'h66}}, 8'hFF, 3'd0, {8'h66, 1'b0, 1'b0});
        in_valid = 1'b0;
        #1;
        check("pre_rst_full", {31'd0, out_valid, in_ready}, 32'h2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 1);
        sb.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        check("post_rst_quiet", {31'd0, out_valid}, 0);
        @(negedge clk);
        send(64'h0000_0000_0000_00F0, 8'h01, 3'd2, {8'hF0, 1'b0, 1'b0});
        in_valid = 1'b0;
`ifdef REDUCE_GATE_CNT_EN
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("cnt_reset", {16'd0, xfer_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 65537; i++) send(64'h0, 8'h00, 3'd0, {8'hFF, 1'b0, 1'b1});
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("cnt_wrap", {16'd0, xfer_cnt}, 1);
`endif
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("final_drain", sb.size(), 0);
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
